// File: rtl/vga_font_arbiter.sv
// Font ROM arbiter: display fetches own the ROM whenever they ask, host reads fill idle cycles.
// A tag pipeline matched to ROM latency routes returning data to the display or host output.
module vga_font_arbiter #(
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vid_req,
  input  logic [11:0] i_vid_addr,
  output logic        o_vid_valid,
  output logic [7:0]  o_vid_data,
  input  logic        i_host_req,
  input  logic [11:0] i_host_addr,
  output logic        o_host_ack,
  output logic [7:0]  o_host_data,
  output logic        o_host_starved,
  input  logic        i_starve_clr,
  output logic [11:0] o_rom_addr,
  input  logic [7:0]  i_rom_data
);

  typedef enum logic [1:0] {IDLE, PEND, WAIT, ACK} host_state_t;

  localparam logic [15:0] STARVE_LIM = 16'(STARVE_MAX);

  host_state_t         state;
  logic [11:0]         host_addr_q;
  logic [11:0]         last_addr_q;
  logic [15:0]         starve_cnt;
  logic [ROM_LAT-1:0]  tag_valid;
  logic [ROM_LAT-1:0]  tag_host;
  logic                host_issue;
  logic                out_valid;
  logic                out_host;

  assign host_issue = !i_vid_req && ((state == IDLE && i_host_req) || state == PEND);
  assign out_valid  = tag_valid[ROM_LAT-1];
  assign out_host   = tag_host[ROM_LAT-1];

  // The address mux is combinational so a display request reaches the ROM in its own cycle.
  always_comb begin
    o_rom_addr = last_addr_q;
    if (i_vid_req) begin
      o_rom_addr = i_vid_addr;
    end else if (host_issue) begin
      o_rom_addr = (state == IDLE) ? i_host_addr : host_addr_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_valid   <= '0;
      tag_host    <= '0;
      last_addr_q <= 12'h000;
      o_vid_valid <= 1'b0;
      o_vid_data  <= 8'h00;
    end else begin
      tag_valid[0] <= i_vid_req | host_issue;
      tag_host[0]  <= !i_vid_req && host_issue;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_host[i]  <= tag_host[i-1];
      end
      last_addr_q <= o_rom_addr;
      o_vid_valid <= out_valid && !out_host;
      if (out_valid && !out_host) begin
        o_vid_data <= i_rom_data;
      end
    end
  end

  // Host handshake; only one host read is ever in flight, so a single HOST tag means ours.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      host_addr_q    <= 12'h000;
      starve_cnt     <= 16'h0000;
      o_host_ack     <= 1'b0;
      o_host_data    <= 8'h00;
      o_host_starved <= 1'b0;
    end else begin
      o_host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_host_req) begin
            host_addr_q <= i_host_addr;
            state       <= i_vid_req ? PEND : WAIT;
          end
        end
        PEND: begin
          if (!i_vid_req) begin
            state      <= WAIT;
            starve_cnt <= 16'h0000;
          end else if (starve_cnt != 16'hFFFF) begin
            starve_cnt <= starve_cnt + 16'h0001;
          end
        end
        WAIT: begin
          if (out_valid && out_host) begin
            state       <= ACK;
            o_host_ack  <= 1'b1;
            o_host_data <= i_rom_data;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Keep re-asserting while still starved so a clear cannot hide an ongoing stall.
      if (state == PEND && starve_cnt >= STARVE_LIM) begin
        o_host_starved <= 1'b1;
      end else if (i_starve_clr) begin
        o_host_starved <= 1'b0;
      end
    end
  end

endmodule

// File: doc/vga_font_arbiter.md
# vga_font_arbiter

Shares the single-port synchronous font ROM (256 glyphs × 16 rows × 8 bit, 12-bit address) between the character-display fetch pipeline and a secondary host read port. Display fetches have absolute priority and fixed latency; host reads use a req/ack handshake and are served in idle ROM cycles. The block tracks in-flight reads through a tag pipeline matched to the ROM latency and raises a sticky flag if the host is starved. It sits between the text-mode pixel pipeline and the font ROM wrapper.

## Interface
- ROM_LAT, 1: cycles from o_rom_addr to valid i_rom_data (1..4)
- STARVE_MAX, 1024: host pending cycles before o_host_starved sets (≤ 65535)
- i_clk  in  1  system/pixel clock
- i_rst  in  1  reset, asynchronous, active-high
- i_vid_req  in  1  display fetch strobe, one read per high cycle
- i_vid_addr  in  12  {char_code[7:0], glyph_row[3:0]}
- o_vid_valid  out  1  display data valid pulse
- o_vid_data  out  8  glyph row bits, MSB = leftmost pixel
- i_host_req  in  1  host read request, level, held until ack
- i_host_addr  in  12  host read address, sampled on request acceptance
- o_host_ack  out  1  one-cycle pulse, o_host_data valid
- o_host_data  out  8  host read data, held until next ack
- o_host_starved  out  1  sticky starvation flag
- i_starve_clr  in  1  clears o_host_starved
- o_rom_addr  out  12  ROM address (combinational mux)
- i_rom_data  in  8  ROM data

## Operation
- Grant per cycle: i_vid_req=1 → o_rom_addr=i_vid_addr, tag VID; else host issue if FSM allows, tag HOST; else o_rom_addr holds last value, tag NONE.
- Tag pipeline: ROM_LAT stages of {valid, src}; at pipeline output, i_rom_data registered into o_vid_data (VID) or o_host_data (HOST); o_vid_valid / o_host_ack pulse in the following cycle.
- Host FSM states IDLE, PEND, WAIT, ACK:
  - IDLE: i_host_req=1 and i_vid_req=0 → issue i_host_addr, latch it, → WAIT. i_host_req=1 and i_vid_req=1 → latch i_host_addr, → PEND.
  - PEND: i_vid_req=0 → issue latched addr, → WAIT; else stay, starve counter +1 (saturating 16 bit).
  - WAIT: HOST tag reaches pipeline output → → ACK.
  - ACK: o_host_ack=1 one cycle; → IDLE. Requester drops i_host_req in the ack cycle; i_host_req high in the cycle after ACK is a new request.
- Only one host read in flight; i_host_addr changes while not IDLE are ignored.
- Starve counter cleared on leaving PEND; counter == STARVE_MAX sets o_host_starved. Set and i_starve_clr in the same cycle: set wins.
- i_vid_req never stalled, never dropped; back-to-back display requests sustain one read per cycle.

## Timing
- Reset values: o_vid_valid 0, o_vid_data 0x00, o_host_ack 0, o_host_data 0x00, o_host_starved 0, o_rom_addr 0x000, FSM IDLE, tags invalid, counter 0.
- Display latency: request cycle N → o_vid_valid in cycle N+ROM_LAT+1; fixed, independent of host traffic.
- Host latency, uncontested: i_host_req rising in cycle N (IDLE) → o_host_ack in N+ROM_LAT+1; each cycle blocked by i_vid_req adds one.
- Reset asserted mid-operation: pipeline flushed, in-flight data discarded, no ack or valid emitted after reset release for pre-reset requests; host must re-request.
- o_rom_addr combinational from inputs and FSM state; all other outputs registered.

## Test plan
- Reset: assert i_rst mid host WAIT → all outputs at reset values next edge; after release, no stray o_host_ack.
- Display stream, ROM_LAT=1: i_vid_req high cycles 0..7, addr 0x410..0x417, ROM model data = addr[7:0] → o_vid_valid cycles 2..9, data 0x10..0x17 in order.
- Uncontested host: i_host_req at cycle 0, addr 0x7A3 → o_rom_addr=0x7A3 cycle 0, o_host_ack cycle 2, o_host_data=0xA3, held after ack.
- Contention: i_vid_req high cycles 0..4, host req at cycle 1 addr 0x123 → host issued cycle 5, ack cycle 7; all display reads on time.
- Starvation, STARVE_MAX=8: i_vid_req continuously high, host req pending → o_host_starved rises after 8 PEND cycles; i_starve_clr pulse while still starving → flag stays 1 (set wins).
- ROM_LAT=3 sweep: random interleaved vid/host traffic → every request answered exactly once, display latency exactly 4, data matches model.
